// File: rtl/ask4_slicer.sv
// rtl/ask4_slicer.sv - 4-ASK symbol downsampler and Gray slicer with error output
//
// Purpose:
//   Consumes the matched-filter sample stream (SPS samples per symbol).
//   Discards FLUSH_LEN samples after reset so the filter cascade can settle.
//   Keeps one sample per symbol period at a programmable phase.
//   Slices that sample to a Gray symbol and outputs the decided level and
//   the slicer error.
//
// Optional feature (macro ASK4_SLICER_ERR_ACC_EN):
//   Averages err^2 over 2^ACC_LOG2 symbols and outputs the mean on err_pow.
//   When the macro is undefined, err_pow and err_pow_valid are tied to 0.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   x_in           in   signed 1s17 sample, one per clk
//   phase          in   sample phase kept within each symbol period
//   thresh         in   signed 1s17 decision threshold (> 0)
//   sym_out        out  decided Gray symbol
//   sym_valid      out  one-cycle strobe qualifying sym_out/y_hat/err
//   y_hat          out  signed 1s17 decided level
//   err            out  signed 1s17 x_in - y_hat, saturated
//   err_pow        out  unsigned mean squared error
//   err_pow_valid  out  one-cycle strobe for err_pow

module ask4_slicer #(
  parameter int WIDTH     = 18,
  parameter int SPS       = 4,
  parameter int LEVEL_A   = 32768,
  parameter int FLUSH_LEN = 40,
  parameter int ACC_LOG2  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic [$clog2(SPS)-1:0]  phase,
  input  logic signed [WIDTH-1:0] thresh,
  output logic [1:0]              sym_out,
  output logic                    sym_valid,
  output logic signed [WIDTH-1:0] y_hat,
  output logic signed [WIDTH-1:0] err,
  output logic [WIDTH-1:0]        err_pow,
  output logic                    err_pow_valid
);

  localparam int PW = $clog2(SPS);
  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

  localparam logic [PW-1:0]           CNT_LAST   = PW'(SPS - 1);
  localparam logic [FW-1:0]           FLUSH_LAST = FW'(FLUSH_LEN - 1);
  localparam logic signed [WIDTH-1:0] LVL_1      = WIDTH'(LEVEL_A);
  localparam logic signed [WIDTH-1:0] LVL_3      = WIDTH'(3 * LEVEL_A);
  localparam logic signed [WIDTH-1:0] ERR_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] ERR_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_FLUSH, S_RUN} state_t;

  state_t                  state_q;
  logic [FW-1:0]           flush_cnt_q;
  logic [PW-1:0]           cnt_q;
  logic [PW-1:0]           phase_r_q;
  logic [1:0]              sym_q, sym_d;
  logic                    sym_valid_q;
  logic signed [WIDTH-1:0] y_hat_q, y_hat_d;
  logic signed [WIDTH-1:0] err_q, err_d;

  // One extra bit so -thresh and x - y_hat cannot overflow.
  logic signed [WIDTH:0]   x_ext, th_ext, th_neg, lvl_ext, diff;
  logic                    capture;

  always_comb begin
    x_ext  = {x_in[WIDTH-1], x_in};
    th_ext = {thresh[WIDTH-1], thresh};
    th_neg = -th_ext;

    // Ties go to the region above the boundary.
    if (x_ext >= th_ext) begin
      sym_d   = 2'b10;
      y_hat_d = LVL_3;
    end else if (!x_ext[WIDTH]) begin
      sym_d   = 2'b11;
      y_hat_d = LVL_1;
    end else if (x_ext >= th_neg) begin
      sym_d   = 2'b01;
      y_hat_d = -LVL_1;
    end else begin
      sym_d   = 2'b00;
      y_hat_d = -LVL_3;
    end

    lvl_ext = {y_hat_d[WIDTH-1], y_hat_d};
    diff    = x_ext - lvl_ext;
    // The top two bits differ only when the difference leaves the WIDTH range.
    if (diff[WIDTH] != diff[WIDTH-1]) begin
      err_d = diff[WIDTH] ? ERR_MIN : ERR_MAX;
    end else begin
      err_d = diff[WIDTH-1:0];
    end
  end

  assign capture = (state_q == S_RUN) && (cnt_q == phase_r_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_FLUSH;
      flush_cnt_q <= '0;
      cnt_q       <= '0;
      phase_r_q   <= phase;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      y_hat_q     <= '0;
      err_q       <= '0;
    end else begin
      sym_valid_q <= 1'b0;
      case (state_q)
        S_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          // SPS is a power of two, so the counter wraps on its own.
          cnt_q <= cnt_q + 1'b1;
          // Reloading only at the period end keeps at most one capture per period.
          if (cnt_q == CNT_LAST) begin
            phase_r_q <= phase;
          end
          if (capture) begin
            sym_q       <= sym_d;
            y_hat_q     <= y_hat_d;
            err_q       <= err_d;
            sym_valid_q <= 1'b1;
          end
        end
        default: state_q <= S_FLUSH;
      endcase
    end
  end

  assign sym_out   = sym_q;
  assign sym_valid = sym_valid_q;
  assign y_hat     = y_hat_q;
  assign err       = err_q;

`ifdef ASK4_SLICER_ERR_ACC_EN
  localparam int AW = 2 * WIDTH + ACC_LOG2;

  logic signed [2*WIDTH-1:0] err_sq;
  logic [AW-1:0]             acc_q, acc_sum, mean_full;
  logic [ACC_LOG2-1:0]       acc_cnt_q;
  logic [WIDTH-1:0]          err_pow_q, err_pow_d;
  logic                      err_pow_valid_q;
  logic                      unused_mean_lsbs;

  always_comb begin
    err_sq    = err_q * err_q;
    // The square is never negative, so zero-extension is exact.
    acc_sum   = acc_q + {{ACC_LOG2{1'b0}}, err_sq};
    mean_full = acc_sum >> ACC_LOG2;
    if (|mean_full[AW-1:2*WIDTH-1]) begin
      err_pow_d = ERR_MAX;
    end else begin
      err_pow_d = mean_full[2*WIDTH-2:WIDTH-1];
    end
  end

  assign unused_mean_lsbs = ^mean_full[WIDTH-2:0];

  // Accumulates on the registered strobe, so err_pow_valid follows the
  // last contributing sym_valid by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q           <= '0;
      acc_cnt_q       <= '0;
      err_pow_q       <= '0;
      err_pow_valid_q <= 1'b0;
    end else begin
      err_pow_valid_q <= 1'b0;
      if (sym_valid_q) begin
        acc_cnt_q <= acc_cnt_q + 1'b1;
        if (acc_cnt_q == {ACC_LOG2{1'b1}}) begin
          err_pow_q       <= err_pow_d;
          err_pow_valid_q <= 1'b1;
          acc_q           <= '0;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end

  assign err_pow       = err_pow_q;
  assign err_pow_valid = err_pow_valid_q;
`else
  assign err_pow       = '0;
  assign err_pow_valid = 1'b0;
`endif

endmodule
